// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential divider: an operand channel and a result channel.
// master drives operands and takes results; slave is the divider itself.
interface seq_divider_if #(
  parameter int DW = 8,
  parameter int VW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, DW steps per operation,
// with valid/ready on both sides, remainder output and divide-by-zero flagging.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_if.slave   bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] shift_reg;
  logic [VW-1:0] part_rem;
  logic [VW-1:0] div_reg;
  logic [CW-1:0] count;
  logic          dz;
  logic [VW:0]   trial;
  logic          q_bit;
  logic [VW-1:0] step_rem;
  logic [DW-1:0] step_shift;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          dz_q;

  // One restoring step; a non-zero divisor keeps the new partial remainder below it, so VW bits suffice
  always_comb begin
    trial      = {part_rem, shift_reg[DW-1]};
    q_bit      = (trial >= {1'b0, div_reg});
    step_rem   = q_bit ? VW'(trial - {1'b0, div_reg}) : trial[VW-1:0];
    step_shift = {shift_reg[DW-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = CALC;
      end
      CALC: begin
        if (count == '0) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result registers only change on the final step, so they hold through DONE and beyond
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      part_rem    <= '0;
      div_reg     <= '0;
      count       <= '0;
      dz          <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shift_reg <= bus.dividend;
            part_rem  <= '0;
            div_reg   <= bus.divisor;
            count     <= CW'(DW - 1);
            dz        <= (bus.divisor == '0);
          end
        end
        CALC: begin
          shift_reg <= step_shift;
          part_rem  <= step_rem;
          count     <= count - CW'(1);
          if (count == '0) begin
            quotient_q  <= dz ? '1 : step_shift;
            remainder_q <= dz ? '0 : step_rem;
            dz_q        <= dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed 8/8 cases, stall/abort behaviour, and a
// randomized 16/5 regression against a plain-arithmetic reference model.
module tb_seq_divider;
  localparam int NOPS = 60;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  seq_divider_if #(.DW(8),  .VW(8)) bus8 ();
  seq_divider_if #(.DW(16), .VW(5)) bus16 ();

  seq_divider #(.DW(8),  .VW(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_divider #(.DW(16), .VW(5)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void refDiv(input int unsigned a, input int unsigned b, input int dwBits,
                                 output int unsigned q, output int unsigned r, output bit z);
    if (b == 0) begin
      q = (32'd1 << dwBits) - 32'd1;
      r = 0;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // One complete operation on the 8-bit unit with the consumer always ready
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    int unsigned eq;
    int unsigned er;
    bit          ez;
    int          waitCnt;
    refDiv(32'(a), 32'(b), 8, eq, er, ez);
    bus8.out_ready = 1'b1;
    waitCnt = 0;
    while (bus8.in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("in_ready timeout", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.dividend = 8'($urandom);
    bus8.divisor  = 8'($urandom);
    waitCnt = 0;
    while (bus8.out_valid !== 1'b1 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput($sformatf("latency %0d/%0d", a, b), 32'(waitCnt), 32'd8);
    checkOutput($sformatf("quotient %0d/%0d", a, b), 32'(bus8.quotient), eq);
    checkOutput($sformatf("remainder %0d/%0d", a, b), 32'(bus8.remainder), er);
    checkOutput($sformatf("div_by_zero %0d/%0d", a, b), 32'(bus8.div_by_zero), 32'(ez));
    @(negedge clk);
    checkOutput($sformatf("in_ready after consume %0d/%0d", a, b), 32'(bus8.in_ready), 32'd1);
  endtask

  int unsigned expQ[$];
  int unsigned expR[$];
  bit          expZ[$];
  int          accepted;
  int          consumed;

  initial begin
    int waitCnt;
    int seenValid;
    checkCount = 0;
    passCount  = 0;
    accepted   = 0;
    consumed   = 0;
    rst = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.dividend   = '0;
    bus8.divisor    = '0;
    bus8.out_ready  = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.dividend  = '0;
    bus16.divisor   = '0;
    bus16.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("reset quotient", 32'(bus8.quotient), 32'd0);
    checkOutput("reset remainder", 32'(bus8.remainder), 32'd0);
    checkOutput("reset div_by_zero", 32'(bus8.div_by_zero), 32'd0);
    checkOutput("reset16 in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("reset16 out_valid", 32'(bus16.out_valid), 32'd0);

    $display("[TB] directed cases");
    applyStimulus(8'd63, 8'd3);
    applyStimulus(8'd200, 8'd7);
    applyStimulus(8'd3, 8'd10);
    applyStimulus(8'd255, 8'd1);
    applyStimulus(8'd5, 8'd0);
    applyStimulus(8'd9, 8'd4);

    $display("[TB] result hold under back-pressure");
    bus8.out_ready = 1'b0;
    waitCnt = 0;
    while (bus8.in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    bus8.in_valid = 1'b1;
    bus8.dividend = 8'd100;
    bus8.divisor  = 8'd9;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    waitCnt = 0;
    while (bus8.out_valid !== 1'b1 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("hold latency", 32'(waitCnt), 32'd8);
    for (int i = 0; i < 10; i++) begin
      bus8.in_valid = i[0];
      bus8.dividend = 8'($urandom);
      bus8.divisor  = 8'($urandom);
      @(negedge clk);
      checkOutput("hold out_valid", 32'(bus8.out_valid), 32'd1);
      checkOutput("hold in_ready", 32'(bus8.in_ready), 32'd0);
      checkOutput("hold quotient", 32'(bus8.quotient), 32'd11);
      checkOutput("hold remainder", 32'(bus8.remainder), 32'd1);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("release out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("release quotient kept", 32'(bus8.quotient), 32'd11);
    applyStimulus(8'd47, 8'd6);

    $display("[TB] reset during calculation");
    waitCnt = 0;
    while (bus8.in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    bus8.in_valid = 1'b1;
    bus8.dividend = 8'd77;
    bus8.divisor  = 8'd5;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("abort quotient", 32'(bus8.quotient), 32'd0);
    checkOutput("abort remainder", 32'(bus8.remainder), 32'd0);
    checkOutput("abort div_by_zero", 32'(bus8.div_by_zero), 32'd0);
    checkOutput("abort in_ready", 32'(bus8.in_ready), 32'd1);
    seenValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.out_valid === 1'b1) seenValid++;
    end
    checkOutput("no result for aborted op", 32'(seenValid), 32'd0);

    $display("[TB] sweep x/3");
    for (int x = 0; x < 64; x++) applyStimulus(8'(x), 8'd3);

    $display("[TB] random regression DW=16 VW=5");
    fork
      begin
        int unsigned a;
        int unsigned b;
        int unsigned q;
        int unsigned r;
        bit          z;
        int          w;
        for (int n = 0; n < NOPS; n++) begin
          bus16.in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = $urandom_range(0, 65535);
          if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
          b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
          bus16.dividend = 16'(a);
          bus16.divisor  = 5'(b);
          bus16.in_valid = 1'b1;
          w = 0;
          while (bus16.in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (w >= 200) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
            break;
          end
          refDiv(a, b, 16, q, r, z);
          expQ.push_back(q);
          expR.push_back(r);
          expZ.push_back(z);
          accepted++;
          @(negedge clk);
        end
        bus16.in_valid = 1'b0;
      end
      begin
        int unsigned q;
        int unsigned r;
        bit          z;
        for (int c = 0; c < 6000 && consumed < NOPS; c++) begin
          bus16.out_ready = ($urandom_range(0, 2) != 0);
          if (bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpected result", 32'd1, 32'd0);
            end else begin
              q = expQ.pop_front();
              r = expR.pop_front();
              z = expZ.pop_front();
              checkOutput($sformatf("rand quotient #%0d", consumed), 32'(bus16.quotient), q);
              checkOutput($sformatf("rand remainder #%0d", consumed), 32'(bus16.remainder), r);
              checkOutput($sformatf("rand div_by_zero #%0d", consumed), 32'(bus16.div_by_zero), 32'(z));
            end
            consumed++;
          end
          @(negedge clk);
        end
      end
    join
    checkOutput("all ops accepted", 32'(accepted), 32'(NOPS));
    checkOutput("consumed equals accepted", 32'(consumed), 32'(accepted));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle unsigned integer divider with valid/ready handshakes on input and output. It produces one quotient bit per clock using restoring division. It replaces fixed lookup-table constant dividers in the camera pixel pipeline, for example the (R+G+B)/3 grayscale averaging and the window-sum normalisation. Both divisor and widths are runtime/parameter selectable, and the block adds a remainder output and divide-by-zero flagging.

## Interface
- DW, default 8: dividend and quotient width in bits; legal range 2..32.
- VW, default 8: divisor and remainder width in bits; legal range 1..DW.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept an operation.
- dividend  input  DW  unsigned dividend; sampled on the accept edge.
- divisor  input  VW  unsigned divisor; sampled on the accept edge.
- out_valid  output  1  result registers hold a finished result.
- out_ready  input  1  consumer takes the result.
- quotient  output  DW  unsigned quotient.
- remainder  output  VW  unsigned remainder.
- div_by_zero  output  1  the result belongs to an operation with divisor == 0.

## Operation
- Reset is synchronous and active-high on clk. When rst is sampled high:
  - state goes to IDLE;
  - in_ready=1 from the following cycle;
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0;
  - the bit counter is cleared.
  - rst overrides any in-flight operation or handshake on the same edge. The in-flight operation is discarded and no output is produced for it.
- State machine states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, latch dividend and divisor and go to CALC.
    - Latching sets the partial remainder to 0, loads the shift register with the dividend, and sets the counter to DW-1.
    - If divisor==0, set the internal dz flag.
  - CALC: in_ready=0, out_valid=0. Each edge performs one restoring step:
    - trial = {partial_rem, dividend MSB}, partial remainder width VW+1;
    - if trial >= divisor: partial_rem = trial - divisor and the quotient bit is 1; otherwise partial_rem = trial and the quotient bit is 0;
    - the quotient bit is shifted into the LSB;
    - counter decrements.
    - The edge processed with counter==0 moves to DONE and loads the output registers.
  - DONE: out_valid=1, in_ready=0. On an edge with out_ready=1, go to IDLE and clear out_valid.
    - quotient, remainder and div_by_zero hold their values after leaving DONE until the next result load.
    - in_valid is ignored while in CALC or DONE.
- Arithmetic:
  - Result satisfies dividend == quotient*divisor + remainder, and remainder < divisor.
  - No truncation is possible, since quotient width DW ≥ dividend width.
- Divide by zero: outputs quotient = all ones (2^DW-1), remainder = 0, div_by_zero=1. Latency is the same as a normal operation; there is no early exit.
- Divisor 1: quotient = dividend, remainder = 0. This is a normal path with no special case.
- Divisor > dividend: quotient = 0, remainder = dividend. The dividend always fits in VW bits here because the remainder is smaller than the divisor.
- Operands are not required to stay stable after the accept edge.

## Timing
- Accept edge: the edge where in_valid=1 and in_ready=1 (IDLE).
- Latency: out_valid rises on exactly the DW-th edge after the accept edge, and is visible in the cycle following that edge.
- Result hold: out_valid stays high for as long as out_ready=0, with all result outputs stable (no-drop, no-change).
- Release: the consume edge (out_valid=1 and out_ready=1) returns the block to IDLE. in_ready=1 in the next cycle.
- Next accept: the earliest next accept is 1 edge after the consume edge.
- Throughput: minimum cycle time per operation is DW+2 edges when out_ready is tied high.
- Outputs: all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then dividend=63, divisor=3, DW=VW=8, out_ready=1 -> out_valid on the 8th edge after accept; quotient=21, remainder=0, div_by_zero=0. Sweep dividend 0..63 with divisor 3 and check against floor(x/3).
- Dividend=200, divisor=7 -> quotient=28, remainder=4. Dividend=3, divisor=10 -> quotient=0, remainder=3. Dividend=255, divisor=1 -> quotient=255, remainder=0.
- Dividend=5, divisor=0 -> quotient=255, remainder=0, div_by_zero=1, 8-cycle latency. The next operation 9/4 -> quotient=2, remainder=1, div_by_zero=0.
- Hold out_ready=0 for 10 cycles after out_valid while toggling in_valid and operands -> outputs stable and in_ready=0 throughout. Assert out_ready -> in_ready=1 one cycle later; the next accept proceeds normally.
- Assert rst on the 4th CALC edge -> next cycle out_valid=0, outputs zero, in_ready=1, and no result ever appears for the aborted operation.
- Random regression at DW=16, VW=5 with random valid/ready stalls -> every result matches the reference model, and the number of consumed results equals the number of accepted operations.
